// File: rtl/multdiv_seq_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit; one bit per cycle.
// Optional macro MULTDIV_EARLY_OUT_EN: zero-operand multiply and divide-by-zero skip straight to DONE.
module multdiv_seq_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_operandA,
    input  logic [DATA_W-1:0] data_operandB,
    input  logic              ctrl_MULT,
    input  logic              ctrl_DIV,
    output logic [DATA_W-1:0] data_result,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic [1:0]        dbg_state
);
    // Handshake: ctrl_MULT/ctrl_DIV are one-cycle start pulses accepted in any state (a
    // start while busy aborts the current op); data_resultRDY is a one-cycle strobe that
    // qualifies data_result/data_exception, which otherwise hold their last completed values.

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;

    // Booth accumulator carries one guard bit so a most-negative multiplicand cannot overflow.
    logic [DATA_W:0]   mul_acc, mul_mcand, mul_sum;
    logic [DATA_W-1:0] mul_mq;
    logic              mul_q1;
    logic [2*DATA_W:0] mul_cat, mul_shift;
    logic [DATA_W:0]   mul_top;
    logic              mul_ovf;

    logic [DATA_W-1:0] div_rem, div_quo, div_dsr, div_res;
    logic              div_neg, div_zero, div_ovf;
    logic [DATA_W:0]   div_sh, div_diff;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic              mul_early, div_early;

`ifdef MULTDIV_EARLY_OUT_EN
    assign mul_early = (data_operandA == '0) || (data_operandB == '0);
    assign div_early = (data_operandB == '0);
`else
    assign mul_early = 1'b0;
    assign div_early = 1'b0;
`endif

    assign a_mag = data_operandA[DATA_W-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign b_mag = data_operandB[DATA_W-1] ? (~data_operandB + 1'b1) : data_operandB;

    always_comb begin
        mul_sum = mul_acc;
        case ({mul_mq[0], mul_q1})
            2'b01:   mul_sum = mul_acc + mul_mcand;
            2'b10:   mul_sum = mul_acc - mul_mcand;
            default: mul_sum = mul_acc;
        endcase
    end

    assign mul_cat   = {mul_sum, mul_mq};
    assign mul_shift = {mul_cat[2*DATA_W], mul_cat[2*DATA_W:1]};
    assign mul_top   = {mul_acc[DATA_W-1:0], mul_mq[DATA_W-1]};
    assign mul_ovf   = !((&mul_top) || !(|mul_top));

    // A negative trial difference shows up in the top bit since the partial remainder stays below 2^DATA_W.
    assign div_sh   = {div_rem, div_quo[DATA_W-1]};
    assign div_diff = div_sh - {1'b0, div_dsr};
    assign div_res  = div_zero ? '0 : (div_neg ? (~div_quo + 1'b1) : div_quo);
    assign div_ovf  = div_zero || (!div_neg && div_quo[DATA_W-1]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ctrl_MULT) begin
            state_nxt = mul_early ? DONE : MUL;
        end else if (ctrl_DIV) begin
            state_nxt = div_early ? DONE : DIV;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                MUL:     state_nxt = (cnt == LAST) ? DONE : MUL;
                DIV:     state_nxt = (cnt == LAST) ? DONE : DIV;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt            <= '0;
            mul_acc        <= '0;
            mul_mcand      <= '0;
            mul_mq         <= '0;
            mul_q1         <= 1'b0;
            div_rem        <= '0;
            div_quo        <= '0;
            div_dsr        <= '0;
            div_neg        <= 1'b0;
            div_zero       <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (ctrl_MULT) begin
            cnt       <= '0;
            mul_acc   <= '0;
            mul_mcand <= {data_operandA[DATA_W-1], data_operandA};
            mul_mq    <= data_operandB;
            mul_q1    <= 1'b0;
            if (mul_early) begin
                data_result    <= '0;
                data_exception <= 1'b0;
            end
        end else if (ctrl_DIV) begin
            cnt      <= '0;
            div_rem  <= '0;
            div_quo  <= a_mag;
            div_dsr  <= b_mag;
            div_neg  <= data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
            div_zero <= (data_operandB == '0);
            if (div_early) begin
                data_result    <= '0;
                data_exception <= 1'b1;
            end
        end else if (state == MUL) begin
            if (cnt == LAST) begin
                data_result    <= mul_mq;
                data_exception <= mul_ovf;
            end else begin
                mul_acc <= mul_shift[2*DATA_W:DATA_W];
                mul_mq  <= mul_shift[DATA_W-1:0];
                mul_q1  <= mul_mq[0];
                cnt     <= cnt + 1'b1;
            end
        end else if (state == DIV) begin
            if (cnt == LAST) begin
                data_result    <= div_res;
                data_exception <= div_ovf;
            end else begin
                if (!div_diff[DATA_W]) begin
                    div_rem <= div_diff[DATA_W-1:0];
                    div_quo <= {div_quo[DATA_W-2:0], 1'b1};
                end else begin
                    div_rem <= div_sh[DATA_W-1:0];
                    div_quo <= {div_quo[DATA_W-2:0], 1'b0};
                end
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign data_resultRDY = (state == DONE);
    assign dbg_state      = state;

endmodule
